// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch handshake: req/gnt for the address phase, rvalid/rdata for the data phase.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS fetch stage: owns the fetch PC and the F/D pipeline register, fetches over req/gnt/rvalid,
// and parks a returned word in a one-entry buffer while the hazard unit stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          npc,
  input  logic                 stall,
  fetch_stage_if.master        imem,
  output logic [31:0]          F_PC,
  output logic [31:0]          D_PC,
  output logic [31:0]          D_instr,
  output logic                 D_valid,
  output logic                 D_exc_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state_reg, state_next;
  logic [31:0] f_pc_reg;
  logic [31:0] d_pc_reg, d_instr_reg;
  logic        d_valid_reg, d_exc_reg;
  logic [31:0] buf_instr_reg;
  logic        buf_exc_reg;

  logic        aligned;
  logic        advance;
  logic        load_buf;
  logic [31:0] res_word;
  logic        res_exc;

  assign aligned = (f_pc_reg[1:0] == 2'b00);

  // A misaligned PC never reaches memory; it resolves immediately as a NOP flagged with AdEL.
  always_comb begin
    state_next = state_reg;
    advance    = 1'b0;
    load_buf   = 1'b0;
    res_word   = NOP_INSTR;
    res_exc    = 1'b0;
    case (state_reg)
      S_REQ: begin
        if (!aligned) begin
          res_exc = 1'b1;
          if (!stall) begin
            advance = 1'b1;
          end else begin
            load_buf   = 1'b1;
            state_next = S_FULL;
          end
        end else if (imem.imem_gnt) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          res_word = imem.imem_rdata;
          if (!stall) begin
            advance    = 1'b1;
            state_next = S_REQ;
          end else begin
            load_buf   = 1'b1;
            state_next = S_FULL;
          end
        end
      end
      S_FULL: begin
        res_word = buf_instr_reg;
        res_exc  = buf_exc_reg;
        if (!stall) begin
          advance    = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_REQ;
      buf_instr_reg <= NOP_INSTR;
      buf_exc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_buf) begin
        buf_instr_reg <= res_word;
        buf_exc_reg   <= res_exc;
      end
    end
  end

  // npc is only meaningful on an advance; it was computed from the pre-edge D contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_reg    <= RESET_PC;
      d_pc_reg    <= RESET_PC;
      d_instr_reg <= NOP_INSTR;
      d_valid_reg <= 1'b0;
      d_exc_reg   <= 1'b0;
    end else if (advance) begin
      f_pc_reg    <= npc;
      d_pc_reg    <= f_pc_reg;
      d_instr_reg <= res_word;
      d_valid_reg <= 1'b1;
      d_exc_reg   <= res_exc;
    end else if (!stall) begin
      d_instr_reg <= NOP_INSTR;
      d_valid_reg <= 1'b0;
      d_exc_reg   <= 1'b0;
    end
  end

  assign imem.imem_req  = !reset && (state_reg == S_REQ) && aligned;
  assign imem.imem_addr = f_pc_reg;

  assign F_PC       = f_pc_reg;
  assign D_PC       = d_pc_reg;
  assign D_instr    = d_instr_reg;
  assign D_valid    = d_valid_reg;
  assign D_exc_adel = d_exc_reg;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the pipelined MIPS core. Owns the architectural fetch PC register (F_PC) and the F/D pipeline register.
- Fetches from an instruction memory over a req/gnt/rvalid handshake.
- Exports F_PC to the next-PC logic and takes back npc, the address to fetch after the current instruction.
- Holds fetched instructions under hazard stalls.

Parameters:
RESET_PC, 32'h0000_3000, fetch address after reset; also the reset value of D_PC.
NOP_INSTR, 32'h0000_0000, instruction word injected for bubbles and for misaligned fetches.

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
npc  in  32  next fetch address from next-PC logic; sampled only on an advance cycle.
stall  in  1  hazard-unit stall; holds F_PC and the F/D register.
F_PC  out  32  PC of the instruction currently being fetched; feeds next-PC logic.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch byte address; always equals F_PC.
imem_gnt  in  1  memory accepted the request this cycle.
imem_rvalid  in  1  read data valid; exactly one per granted request.
imem_rdata  in  32  instruction word.
D_PC  out  32  PC of the instruction in D.
D_instr  out  32  instruction in D.
D_valid  out  1  D holds a real instruction; 0 means bubble.
D_exc_adel  out  1  instruction in D came from a misaligned fetch (F_PC[1:0] != 0).

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - F_PC = RESET_PC, D_PC = RESET_PC, D_instr = NOP_INSTR, D_valid = 0, D_exc_adel = 0.
  - State = S_REQ; internal buffer cleared.
  - imem_req is forced 0 while reset is high.
- States:
  - S_REQ: imem_req = 1 when F_PC is aligned. On imem_gnt go to S_WAIT. While not granted, hold req and addr stable.
  - S_WAIT: imem_req = 0; wait for imem_rvalid.
    - rvalid & !stall: advance, then go to S_REQ.
    - rvalid & stall: copy rdata into the 1-entry buffer, go to S_FULL.
  - S_FULL: imem_req = 0. When !stall: advance from the buffer, go to S_REQ.
- Misaligned F_PC in S_REQ:
  - No request is issued.
  - Treated as an immediate result with word NOP_INSTR and exc = 1.
  - !stall: advance this cycle. stall: go to S_FULL holding NOP and the exc flag.
- Advance cycle, all at the rising edge:
  - D_PC <= F_PC, D_instr <= word, D_valid <= 1, D_exc_adel <= exc.
  - F_PC <= npc.
  - npc is sampled only here. It is derived from the pre-edge D contents, which implements the delay slot.
  - Next-PC logic must present F_PC+4 when D_valid = 0.
- Non-advance cycle:
  - stall = 1: the D register holds all fields.
  - stall = 0: D_valid <= 0, D_instr <= NOP_INSTR, D_exc_adel <= 0; D_PC holds.
  - F_PC holds.
- stall has no effect on an outstanding handshake: a granted request always completes, and rvalid is never dropped.
- imem_rvalid outside S_WAIT is a protocol violation and is ignored. imem_gnt outside S_REQ is ignored.
- Throughput:
  - Zero-wait memory (gnt same cycle as req, rvalid next cycle): one instruction per 2 cycles.
  - First advance is in the cycle after the gnt cycle.
- F_PC + arithmetic in next-PC logic wraps mod 2^32; this block applies no range check besides alignment.
- Reset asserted mid-operation (S_WAIT or S_FULL): the in-flight or buffered instruction is discarded; the block restarts at RESET_PC. Memory is reset by the same signal.
- No combinational path from imem_rdata or npc to any output. F_PC and all D outputs are registered.

Test Plan:
1. Reset release, zero-wait memory returning 0x2408_0001 at 0x3000 and 0x2409_0002 at 0x3004, npc = F_PC+4:
   - imem_addr = 0x3000 on first req.
   - D_PC = 0x3000, D_instr = 0x2408_0001, D_valid = 1 on the edge after the rvalid cycle.
   - F_PC = 0x3004; second instruction reaches D two cycles later.
2. Memory with 3-cycle gnt delay and 2-cycle rvalid delay:
   - imem_req and imem_addr stay 0x3004 until gnt.
   - D_valid = 0 for each waiting cycle.
   - No duplicate request is issued.
3. stall held high for 4 cycles, asserted on the rvalid cycle of 0x3008:
   - Word is buffered; D holds the previous instruction.
   - On stall release, D_PC = 0x3008 with the correct word next edge.
   - F_PC changes only then.
4. D holds beq at 0x3010; npc = 0x3040 presented on the advance of 0x3014:
   - 0x3014 (delay slot) enters D.
   - F_PC becomes 0x3040; the next imem_addr is 0x3040.
5. npc = 0x3042:
   - No imem_req.
   - D_PC = 0x3042, D_instr = 0, D_exc_adel = 1, D_valid = 1.
6. Assert reset in S_WAIT at 0x3020:
   - All outputs return to reset values immediately, without a clock edge.
   - After release, the first imem_addr is 0x3000; the stale rvalid is ignored.
